// File: rtl/ucode_loader_pkg.sv
// Shared definitions for the microcode loader: FSM state encoding, default store geometry
// and the bytes-per-word derivation.
package ucode_loader_pkg;

  localparam int UCODE_WORD_WIDTH = 56;
  localparam int UCODE_ADDR_WIDTH = 12;
  localparam int UCODE_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } ld_state_t;

  function automatic int ucode_nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/ucode_word_assembler.sv
// Byte-to-microword assembler: NBYTES-deep shift register, MS byte first, output truncated to
// WORD_WIDTH so the surplus top bits of the first byte fall away.
module ucode_word_assembler
  import ucode_loader_pkg::*;
#(
  parameter int WORD_WIDTH = UCODE_WORD_WIDTH,
  parameter int NBYTES     = ucode_nbytes(WORD_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [7:0]            in_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int CW = $clog2(NBYTES + 1);

  logic [NBYTES*8-1:0] shreg;
  logic [CW-1:0]       byte_cnt;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg    <= (NBYTES*8)'({shreg, in_data});
      byte_cnt <= word_full ? '0 : byte_cnt + 1'b1;
    end
  end

  // Raised while the next shifted byte is the one that completes the word.
  assign word_full = (byte_cnt == CW'(NBYTES - 1));
  assign word      = shreg[WORD_WIDTH-1:0];

endmodule

// File: rtl/ucode_loader.sv
// Microcode control-store writer: parses count/data/checksum from a byte stream, writes words
// at increasing addresses and releases the Sequencer only once the checksum matches.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CNT_HI  | accepting word-count high byte
// CNT_LO  | accepting word-count low byte, range check
// DATA    | accepting data bytes into the assembler and checksum
// WRITE   | one-cycle control-store write, in_ready low
// CHECK   | accepting checksum byte
// DONE    | image good, Sequencer released
// ERROR   | bad size or checksum, Sequencer held
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int WORD_WIDTH = UCODE_WORD_WIDTH,
  parameter int ADDR_WIDTH = UCODE_ADDR_WIDTH,
  parameter int NBYTES     = ucode_nbytes(WORD_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cs_we,
  output logic [ADDR_WIDTH-1:0] cs_addr,
  output logic [WORD_WIDTH-1:0] cs_wdata,
  output logic                  seq_hold,
  output logic                  done,
  output logic                  error
);

  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [UCODE_CNT_WIDTH:0] MAX_WORDS = (UCODE_CNT_WIDTH+1)'(1) << ADDR_WIDTH;

  ld_state_t                  state;
  logic [UCODE_CNT_WIDTH-1:0] n_words;
  logic [UCODE_CNT_WIDTH-1:0] n_rx;
  logic [IW-1:0]              idx;
  logic [IW-1:0]              idx_nxt;
  logic [7:0]                 sum;
  logic                       xfer;
  logic                       armable;
  logic                       asm_clear;
  logic                       asm_shift;
  logic                       asm_last;

  assign xfer      = in_valid & in_ready;
  assign n_rx      = {n_words[15:8], in_data};
  assign idx_nxt   = idx + 1'b1;
  assign armable   = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
  assign asm_clear = start && armable;
  assign asm_shift = xfer && (state == ST_DATA);

  ucode_word_assembler #(
    .WORD_WIDTH(WORD_WIDTH),
    .NBYTES    (NBYTES)
  ) u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear    (asm_clear),
    .shift    (asm_shift),
    .in_data  (in_data),
    .word     (cs_wdata),
    .word_full(asm_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      cs_we    <= 1'b0;
      cs_addr  <= '0;
      seq_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      n_words  <= '0;
      idx      <= '0;
      sum      <= '0;
    end else begin
      cs_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_CNT_HI;
            in_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            seq_hold <= 1'b1;
            sum      <= '0;
            idx      <= '0;
            cs_addr  <= '0;
          end
        end
        ST_CNT_HI: begin
          if (xfer) begin
            n_words[15:8] <= in_data;
            state         <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (xfer) begin
            n_words[7:0] <= in_data;
            if ({1'b0, n_rx} > MAX_WORDS) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (n_rx == '0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            sum <= sum + in_data;
            if (asm_last) begin
              state    <= ST_WRITE;
              in_ready <= 1'b0;
              cs_we    <= 1'b1;
              cs_addr  <= idx[ADDR_WIDTH-1:0];
            end
          end
        end
        ST_WRITE: begin
          idx      <= idx_nxt;
          in_ready <= 1'b1;
          // Index is one bit wider than the address so a full store reads as N, not 0.
          if (32'(idx_nxt) == 32'(n_words)) state <= ST_CHECK;
          else                              state <= ST_DATA;
        end
        ST_CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              seq_hold <= 1'b0;
            end else begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              seq_hold <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// Bench for ucode_loader: table of load scenarios plus random loads against a stream-level model,
// with hand sequences for reset mid-load and a full 4096-word store.
module tb_ucode_loader;
  import ucode_loader_pkg::*;

  localparam int WW = 56;
  localparam int AW = 12;
  localparam int NB = 7;

  typedef logic [WW-1:0] wq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;
  typedef struct {
    int n;
    int pat;
    bit chk_bad;
    bit gaps;
    bit busy_start;
    bit exp_done;
    bit exp_error;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          cs_we;
  logic [AW-1:0] cs_addr;
  logic [WW-1:0] cs_wdata;
  logic          seq_hold;
  logic          done;
  logic          error;

  int total = 0;
  int bad   = 0;

  wr_t           got_q[$];
  logic [WW-1:0] ram[0:(1<<AW)-1];
  bit            mon_en = 1'b0;
  int            viol   = 0;

  always #5 clock = ~clock;

  ucode_loader #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cs_we   (cs_we),
    .cs_addr (cs_addr),
    .cs_wdata(cs_wdata),
    .seq_hold(seq_hold),
    .done    (done),
    .error   (error)
  );

  // During a load, in_ready may only be low in write cycles, and never together with a write.
  always @(negedge clock) begin
    if (mon_en) begin
      if (cs_we) begin
        got_q.push_back('{cs_addr, cs_wdata});
        ram[cs_addr] = cs_wdata;
      end
      if (cs_we && in_ready) viol++;
      if (!cs_we && !in_ready && !done && !error) viol++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit taken);
    int w;
    taken = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    w = 0;
    while (w < 40 && !taken) begin
      if (in_ready) taken = 1'b1;
      @(negedge clock);
      w++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input wq_t words, input bit chk_bad, input bit gaps,
                          input bit busy_start, input bit exp_done, input bit exp_error);
    logic [7:0]  bytes[$];
    logic [7:0]  s;
    logic [15:0] nn;
    logic [WW-1:0] w;
    bit          taken;
    int          acc;
    int          exp_acc;
    int          exp_wr;
    int          k;
    s  = 8'h00;
    nn = 16'(n);
    bytes.push_back(nn[15:8]);
    bytes.push_back(nn[7:0]);
    foreach (words[i]) begin
      w = words[i];
      for (int b = NB - 1; b >= 0; b--) begin
        bytes.push_back(w[b*8 +: 8]);
        s = s + w[b*8 +: 8];
      end
    end
    bytes.push_back(chk_bad ? s + 8'd1 : s);
    exp_acc = (n > (1 << AW)) ? 2 : 3 + n * NB;
    exp_wr  = (n > (1 << AW)) ? 0 : n;

    got_q.delete();
    viol = 0;
    pulse_start();
    chk("start_hold", 64'(seq_hold), 64'd1);
    chk("start_clear", 64'({done, error}), 64'd0);
    mon_en = 1'b1;
    acc = 0;
    k = 0;
    taken = 1'b1;
    while (k < bytes.size() && taken) begin
      if (busy_start && k == 3) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      send_byte(bytes[k], gaps, taken);
      if (taken) acc++;
      k++;
    end
    for (int t = 0; t < 20 && !(done || error); t++) @(negedge clock);
    mon_en = 1'b0;

    chk("accepted_bytes", 64'(acc), 64'(exp_acc));
    chk("write_count", 64'(got_q.size()), 64'(exp_wr));
    for (int i = 0; i < got_q.size() && i < exp_wr; i++) begin
      chk("write_addr", 64'(got_q[i].addr), 64'(i));
      chk("write_data", 64'(got_q[i].data), 64'(words[i]));
    end
    chk("done", 64'(done), 64'(exp_done));
    chk("error", 64'(error), 64'(exp_error));
    chk("seq_hold", 64'(seq_hold), 64'(!exp_done));
    chk("ready_rule", 64'(viol), 64'd0);
  endtask

  function automatic wq_t make_words(input int n, input int pat);
    wq_t q;
    if (n <= (1 << AW)) begin
      for (int i = 0; i < n; i++) begin
        case (pat)
          0:       q.push_back((i == 0) ? 56'h01020304050607 : 56'h11223344556677);
          2:       q.push_back({8'hA5, 48'(i * 3 + 1)});
          default: q.push_back(WW'({$urandom, $urandom}));
        endcase
      end
    end
    return q;
  endfunction

  initial begin
    vec_t vt[10];
    wq_t  words;
    int   n;
    bit   cb;
    bit   taken;
    logic [7:0] rst_stream[6];

    // Nominal image: data bytes sum to 0xF8 mod 256; the model derives it from the words.
    vt[0] = '{2,     0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{2,     0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{0,     1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{0,     1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{4097,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[5] = '{2,     0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1,     1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7] = '{5,     1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8] = '{3,     1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[9] = '{65535, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(cs_we), 64'd0);
    chk("rst_addr", 64'(cs_addr), 64'd0);
    chk("rst_wdata", 64'(cs_wdata), 64'd0);
    chk("rst_hold", 64'(seq_hold), 64'd1);
    chk("rst_done_err", 64'({done, error}), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 10; v++) begin
      words = make_words(vt[v].n, vt[v].pat);
      run_load(vt[v].n, words, vt[v].chk_bad, vt[v].gaps, vt[v].busy_start,
               vt[v].exp_done, vt[v].exp_error);
    end

    for (int r = 0; r < 6; r++) begin
      n     = $urandom_range(1, 8);
      cb    = ($urandom_range(0, 3) == 0);
      words = make_words(n, 1);
      run_load(n, words, cb, 1'b1, 1'b0, !cb, cb);
    end

    // Reset after the fourth data byte of the nominal stream, then reload.
    rst_stream = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    pulse_start();
    foreach (rst_stream[i]) send_byte(rst_stream[i], 1'b0, taken);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_we", 64'(cs_we), 64'd0);
    chk("mid_rst_addr", 64'(cs_addr), 64'd0);
    chk("mid_rst_wdata", 64'(cs_wdata), 64'd0);
    chk("mid_rst_hold", 64'(seq_hold), 64'd1);
    chk("mid_rst_done_err", 64'({done, error}), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    words = make_words(2, 0);
    run_load(2, words, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full store: last write at the all-ones address, word 0 visible to a Sequencer starting at 0.
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    words = make_words(1 << AW, 2);
    run_load(1 << AW, words, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    if (got_q.size() > 0) chk("full_last_addr", 64'(got_q[got_q.size()-1].addr), 64'hFFF);
    else                  chk("full_last_addr", 64'hDEAD, 64'hFFF);
    chk("full_cs_addr_hold", 64'(cs_addr), 64'hFFF);
    chk("seq_fetch_word0", 64'(ram[0]), 64'(words[0]));
    chk("seq_released", 64'(seq_hold), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
